mux_arb_n: RTL and testbench
============================

MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter N, default 8, number of input channels (N >= 2).
REQ-003 Parameter SELW, default 3, channel-index width equal to clog2(N).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous reset, active-high.
REQ-006 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  channel i is offering a word.
REQ-008 in_ready  output  N  channel i's word is accepted this cycle.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-010 sel  input  SELW  channel index used in fixed-select mode.
REQ-011 out_data  output  WIDTH  registered output word.
REQ-012 out_chan  output  SELW  source channel of out_data.
REQ-013 out_valid  output  1  out_data/out_chan hold a word.
REQ-014 out_ready  input  1  downstream accepts the word this cycle.

Function
REQ-015 The block SHALL have one output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load_en SHALL equal (!out_valid || out_ready), so the register accepts a word when EMPTY or when it is draining in the same cycle.
REQ-017 In mode 0, the grant SHALL be channel sel when in_valid[sel]=1; otherwise there is no grant.
REQ-018 In mode 0 with sel >= N (N not a power of 2), there SHALL be no grant and in_ready SHALL be all zero.
REQ-019 In mode 1, the grant SHALL be the first channel with in_valid=1, searching from ptr+1 upward and wrapping modulo N (ptr itself is checked last).
REQ-020 At most one in_ready bit SHALL be high, and only for the granted channel while load_en=1; in_ready SHALL be purely combinational from in_valid, mode, sel, ptr and load_en.
REQ-021 A transfer (in_valid[g] && in_ready[g]) SHALL load out_data, out_chan and set out_valid on the next edge. Latency is one cycle.
REQ-022 A pop with no transfer (out_valid && out_ready) SHALL clear out_valid. out_data and out_chan SHALL hold their last values.
REQ-023 A simultaneous pop and transfer SHALL replace the word and keep out_valid=1, giving a sustained throughput of one word per cycle.
REQ-024 When FULL and out_ready=0, out_data, out_chan and out_valid SHALL hold, and in_ready SHALL be all zero.
REQ-025 ptr SHALL update to the granted index on every transfer in mode 1 only. ptr SHALL hold in mode 0.
REQ-026 A mode or sel change SHALL affect the grant in the same cycle (combinational). A word already registered SHALL be unaffected.
REQ-027 Inputs on channels that are not granted SHALL be ignored. No data is dropped or duplicated.

Reset
REQ-028 rst=1 SHALL asynchronously force out_valid=0, out_data=0, out_chan=0 and ptr=N-1, so the first round-robin search starts at channel 0.
REQ-029 in_ready SHALL be all zero while rst=1.
REQ-030 A reset asserted while FULL SHALL discard the held word with no handshake. No transfer occurs on the edge where rst is high.
REQ-031 After rst deasserts, the first transfer SHALL be possible on the first rising edge with rst=0.

Verification
REQ-032 Reset, then mode=0, sel=5, in_valid=8'h20, ch5=16'hBEEF, out_ready=1 -> in_ready=8'h20; next cycle out_valid=1, out_data=16'hBEEF, out_chan=5.
REQ-033 mode=0, sel=2, in_valid=8'hFB (ch2 idle) -> in_ready=0 and out_valid stays 0.
REQ-034 mode=1, in_valid=8'hFF held, out_ready=1, 10 cycles after reset -> out_chan sequence 0,1,2,...,7,0,1 with one word per cycle.
REQ-035 mode=1, in_valid=8'h81, out_ready=1 -> out_chan alternates 0,7,0,7.
REQ-036 FULL with ch3=16'h1234, out_ready=0 for 3 cycles while ch4 is valid -> out_data holds 16'h1234, in_ready=0. Raising out_ready -> pop and load of ch4 happen on the same edge.
REQ-037 rst pulsed mid-stream while FULL -> out_valid=0, out_data=0 immediately (before the next edge). The next round-robin grant after release is the lowest valid channel.

Source files
------------

// File: rtl/mux_arb_n.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arb_n
//  Description : N-channel mux/arbiter (fixed select or round-robin) feeding a
//                single registered output slot with valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_arb_n #(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int SELW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             w_load_en;
  logic             w_xfer;
  logic             w_fx_vld;
  logic             w_rr_vld;
  logic [SELW-1:0]  w_rr_idx;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_gnt_idx;
  logic [WIDTH-1:0] w_gnt_data;
  logic [SELW:0]    w_shamt;
  logic [N-1:0]     w_rot;

  assign w_load_en = !out_valid_q || out_ready;

  // Out-of-range sel (N not a power of two) never grants.
  assign w_fx_vld = (32'(sel) < 32'(N)) && in_valid[sel];

  // Rotate in_valid so bit 0 is channel ptr+1; ptr itself lands in bit N-1.
  assign w_shamt = {1'b0, ptr_q} + (SELW+1)'(1);
  assign w_rot   = N'({in_valid, in_valid} >> w_shamt);

  always_comb begin
    w_rr_vld = 1'b0;
    w_rr_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = SELW'((int'(ptr_q) + 1 + k) % N);
      end
    end
  end

  assign w_gnt_vld = mode ? w_rr_vld : w_fx_vld;
  assign w_gnt_idx = mode ? w_rr_idx : sel;
  assign w_xfer    = w_gnt_vld && w_load_en && !rst;

  always_comb begin
    in_ready   = '0;
    w_gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt_idx == SELW'(i)) begin
        in_ready[i] = w_xfer;
        w_gnt_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (w_xfer) begin
      out_data_d  = w_gnt_data;
      out_chan_d  = w_gnt_idx;
      out_valid_d = 1'b1;
      if (mode) ptr_d = w_gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SELW'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_arb_n
//  Description : Directed self-checking bench for mux_arb_n (N=8, WIDTH=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_arb_n;

  localparam int WIDTH = 16;
  localparam int N     = 8;
  localparam int SELW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic              mode;
  logic [SELW-1:0]   sel;
  logic [WIDTH-1:0]  out_data;
  logic [SELW-1:0]   out_chan;
  logic              out_valid;
  logic              out_ready;

  logic [WIDTH-1:0]  ch [N];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = ch[i];
  end

  mux_arb_n #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  valid;
    logic        rdy;
    logic [7:0]  exp_ir;
    logic        exp_ov;
    logic [2:0]  exp_ch;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic init_data();
    for (int i = 0; i < N; i++) ch[i] = 16'hA000 + 16'(i);
    ch[5] = 16'hBEEF;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = '0;
    repeat (2) @(negedge clk);
    #1 check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_chan", 32'(out_chan), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
    init_data();

    vecs[0] = '{1'b0, 3'd5, 8'h20, 1'b1, 8'h20, 1'b1, 3'd5, 16'hBEEF};
    vecs[1] = '{1'b0, 3'd2, 8'hFB, 1'b1, 8'h00, 1'b0, 3'd5, 16'hBEEF};
    vecs[2] = '{1'b0, 3'd2, 8'hFB, 1'b1, 8'h00, 1'b0, 3'd5, 16'hBEEF};
    vecs[3] = '{1'b0, 3'd0, 8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 16'hA000};
    vecs[4] = '{1'b0, 3'd1, 8'h02, 1'b0, 8'h00, 1'b1, 3'd0, 16'hA000};
    vecs[5] = '{1'b0, 3'd1, 8'h02, 1'b1, 8'h02, 1'b1, 3'd1, 16'hA001};
    vecs[6] = '{1'b0, 3'd7, 8'h80, 1'b1, 8'h80, 1'b1, 3'd7, 16'hA007};
    vecs[7] = '{1'b0, 3'd6, 8'h00, 1'b1, 8'h00, 1'b0, 3'd7, 16'hA007};

    // Fixed-select table
    do_reset();
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      mode = vecs[v].mode; sel = vecs[v].sel;
      in_valid = vecs[v].valid; out_ready = vecs[v].rdy;
      #1 check($sformatf("vec%0d_in_ready", v), 32'(in_ready), 32'(vecs[v].exp_ir));
      @(posedge clk); #1;
      check($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].exp_ov));
      check($sformatf("vec%0d_out_chan", v), 32'(out_chan), 32'(vecs[v].exp_ch));
      check($sformatf("vec%0d_out_data", v), 32'(out_data), 32'(vecs[v].exp_d));
    end

    // Round-robin, all channels valid: 0..7,0,1 one word per cycle
    do_reset();
    @(negedge clk);
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1 check($sformatf("rr_all_in_ready%0d", c), 32'(in_ready), 32'(8'h01 << (c % 8)));
      @(posedge clk); #1;
      check($sformatf("rr_all_chan%0d", c), 32'(out_chan), 32'(c % 8));
      check($sformatf("rr_all_valid%0d", c), 32'(out_valid), 32'd1);
      check($sformatf("rr_all_data%0d", c), 32'(out_data), 32'(ch[c % 8]));
      @(negedge clk);
    end

    // Round-robin, channels 0 and 7 alternate
    do_reset();
    @(negedge clk);
    mode = 1'b1; in_valid = 8'h81; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("rr_81_chan%0d", c), 32'(out_chan), (c % 2 == 0) ? 32'd0 : 32'd7);
      check($sformatf("rr_81_valid%0d", c), 32'(out_valid), 32'd1);
    end

    // Backpressure: hold ch3 word, then pop + load ch4 on the same edge
    do_reset();
    @(negedge clk);
    ch[3] = 16'h1234;
    mode = 1'b0; sel = 3'd3; in_valid = 8'h08; out_ready = 1'b0;
    @(posedge clk); #1;
    check("bp_load_data", 32'(out_data), 32'h1234);
    @(negedge clk);
    sel = 3'd4; in_valid = 8'h10;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("bp_in_ready%0d", c), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check($sformatf("bp_hold_data%0d", c), 32'(out_data), 32'h1234);
      check($sformatf("bp_hold_chan%0d", c), 32'(out_chan), 32'd3);
      check($sformatf("bp_hold_valid%0d", c), 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("bp_release_in_ready", 32'(in_ready), 32'h10);
    @(posedge clk); #1;
    check("bp_release_data", 32'(out_data), 32'hA004);
    check("bp_release_chan", 32'(out_chan), 32'd4);
    check("bp_release_valid", 32'(out_valid), 32'd1);

    // Async reset mid-stream while FULL, then lowest valid channel wins
    init_data();
    @(negedge clk);
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", 32'(out_data), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("rst_edge_no_xfer", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 8'h0C;
    #1 check("post_rst_in_ready", 32'(in_ready), 32'h04);
    @(posedge clk); #1;
    check("post_rst_chan", 32'(out_chan), 32'd2);
    check("post_rst_data", 32'(out_data), 32'hA002);
    check("post_rst_valid", 32'(out_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
